difftest_arch_event_src: RTL and testbench

DIFFTEST_ARCH_EVENT_SRC -- requirements
Module: difftest_arch_event_src

---
 rtl/difftest_arch_event_src.sv | 159 +++++++++++++++
 tb/tb_difftest_arch_event_src.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/difftest_arch_event_src.sv
// -----------------------------------------------------------------------------
// difftest_arch_event_src
//
// Buffers architectural trap events (interrupts / exceptions) from the commit
// stage and presents them one at a time to a difftest checker over a
// valid/ready handshake. A candidate event is "real" only when at least one
// cause is nonzero; other candidates are ignored. Real events that arrive
// while the buffer cannot accept them are dropped and flagged on a sticky
// overflow bit. Delivered events are counted by a saturating counter.
//
// Parameters
//   DEPTH  FIFO entry count (power of two, >= 2)
//   CNT_W  width of the delivered-event counter
//
// Ports
//   clock               single clock, rising-edge
//   reset               synchronous, active-high
//   in_valid            commit stage presents a candidate event
//   in_interrupt[31:0]  interrupt cause, 0 = none
//   in_exception[31:0]  exception cause, 0 = none
//   in_exception_pc     PC of trapping instruction (64 bits)
//   in_exception_inst   encoding of trapping instruction (32 bits)
//   in_coreid[7:0]      hart id
//   in_ready            buffer can accept an event this cycle
//   out_ready           checker consumes the head event this cycle
//   out_valid           head event valid
//   out_*               head-entry fields, all-zero when empty
//   overflow            sticky: a real event was dropped
//   event_count         number of events delivered (saturating)
// -----------------------------------------------------------------------------
module difftest_arch_event_src #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [31:0]      in_interrupt,
   input  logic [31:0]      in_exception,
   input  logic [63:0]      in_exception_pc,
   input  logic [31:0]      in_exception_inst,
   input  logic [7:0]       in_coreid,
   output logic             in_ready,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [31:0]      out_interrupt,
   output logic [31:0]      out_exception,
   output logic [63:0]      out_exception_pc,
   output logic [31:0]      out_exception_inst,
   output logic [7:0]       out_coreid,
   output logic             overflow,
   output logic [CNT_W-1:0] event_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_FW = PTR_W + 1;   // must represent 0..DEPTH inclusive

   typedef struct packed {
      logic [31:0] interrupt;
      logic [31:0] exception;
      logic [63:0] pc;
      logic [31:0] inst;
      logic [7:0]  coreid;
   } entry_t;

   entry_t             mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_FW-1:0]  count_q, count_d;
   logic               overflow_q, overflow_d;
   logic [CNT_W-1:0]   event_count_q, event_count_d;

   logic               is_real;
   logic               do_enq;
   logic               do_deq;
   entry_t             in_entry;
   entry_t             head;

   // Handshake decode. A dequeue frees a slot in the same cycle, so a full
   // buffer still accepts when the checker is draining it.
   always_comb begin
      out_valid = (count_q != '0);
      do_deq    = out_valid && out_ready;
      in_ready  = (count_q < CNT_FW'(DEPTH)) || do_deq;
      is_real   = in_valid && ((in_interrupt != '0) || (in_exception != '0));
      do_enq    = is_real && in_ready;

      in_entry.interrupt = in_interrupt;
      in_entry.exception = in_exception;
      in_entry.pc        = in_exception_pc;
      in_entry.inst      = in_exception_inst;
      in_entry.coreid    = in_coreid;
   end

   // Next-state logic.
   // NOTE: every signal gets a default at the top of the block, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      overflow_d    = overflow_q;
      event_count_d = event_count_q;

      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);

      case ({do_enq, do_deq})
         2'b10:   count_d = count_q + CNT_FW'(1);
         2'b01:   count_d = count_q - CNT_FW'(1);
         default: count_d = count_q;
      endcase

      if (is_real && !in_ready) overflow_d = 1'b1;

      if (do_deq && (event_count_q != '1)) event_count_d = event_count_q + CNT_W'(1);
   end

   // Control state.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // its pre-edge value regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         overflow_q    <= 1'b0;
         event_count_q <= '0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         overflow_q    <= overflow_d;
         event_count_q <= event_count_d;
      end
   end

   // Entry storage.
   // NOTE: the storage array is deliberately not reset; stale contents are
   // unreachable because out_valid is derived from the reset count.
   always_ff @(posedge clock) begin
      if (!reset && do_enq) mem_q[wr_ptr_q] <= in_entry;
   end

   // Head presentation, forced to zero when empty so the checker never sees
   // stale fields.
   always_comb begin
      head               = out_valid ? mem_q[rd_ptr_q] : '0;
      out_interrupt      = head.interrupt;
      out_exception      = head.exception;
      out_exception_pc   = head.pc;
      out_exception_inst = head.inst;
      out_coreid         = head.coreid;
      overflow           = overflow_q;
      event_count        = event_count_q;
   end

endmodule

// File: tb/tb_difftest_arch_event_src.sv
// -----------------------------------------------------------------------------
// tb_difftest_arch_event_src
//
// Directed bench for difftest_arch_event_src. Two instances share the same
// stimulus: dut_a with the default counter width and dut_b with CNT_W=2 to
// observe counter saturation. Inputs change and outputs are sampled 1 ns
// after each rising edge.
// -----------------------------------------------------------------------------
module tb_difftest_arch_event_src;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic [31:0] in_interrupt;
   logic [31:0] in_exception;
   logic [63:0] in_exception_pc;
   logic [31:0] in_exception_inst;
   logic [7:0]  in_coreid;
   logic        out_ready;

   logic        a_in_ready, a_out_valid, a_overflow;
   logic [31:0] a_out_interrupt, a_out_exception, a_out_exception_inst;
   logic [63:0] a_out_exception_pc;
   logic [7:0]  a_out_coreid;
   logic [15:0] a_event_count;

   logic        b_in_ready, b_out_valid, b_overflow;
   logic [31:0] b_out_interrupt, b_out_exception, b_out_exception_inst;
   logic [63:0] b_out_exception_pc;
   logic [7:0]  b_out_coreid;
   logic [1:0]  b_event_count;

   int checks = 0;
   int errors = 0;

   difftest_arch_event_src #(.DEPTH(4), .CNT_W(16)) dut_a (
      .clock              (clock),
      .reset              (reset),
      .in_valid           (in_valid),
      .in_interrupt       (in_interrupt),
      .in_exception       (in_exception),
      .in_exception_pc    (in_exception_pc),
      .in_exception_inst  (in_exception_inst),
      .in_coreid          (in_coreid),
      .in_ready           (a_in_ready),
      .out_ready          (out_ready),
      .out_valid          (a_out_valid),
      .out_interrupt      (a_out_interrupt),
      .out_exception      (a_out_exception),
      .out_exception_pc   (a_out_exception_pc),
      .out_exception_inst (a_out_exception_inst),
      .out_coreid         (a_out_coreid),
      .overflow           (a_overflow),
      .event_count        (a_event_count)
   );

   difftest_arch_event_src #(.DEPTH(4), .CNT_W(2)) dut_b (
      .clock              (clock),
      .reset              (reset),
      .in_valid           (in_valid),
      .in_interrupt       (in_interrupt),
      .in_exception       (in_exception),
      .in_exception_pc    (in_exception_pc),
      .in_exception_inst  (in_exception_inst),
      .in_coreid          (in_coreid),
      .in_ready           (b_in_ready),
      .out_ready          (out_ready),
      .out_valid          (b_out_valid),
      .out_interrupt      (b_out_interrupt),
      .out_exception      (b_out_exception),
      .out_exception_pc   (b_out_exception_pc),
      .out_exception_inst (b_out_exception_inst),
      .out_coreid         (b_out_coreid),
      .overflow           (b_overflow),
      .event_count        (b_event_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic drive_event(input logic [31:0] irq, input logic [31:0] exc,
                              input logic [63:0] pc, input logic [31:0] inst,
                              input logic [7:0] core);
      in_valid          = 1'b1;
      in_interrupt      = irq;
      in_exception      = exc;
      in_exception_pc   = pc;
      in_exception_inst = inst;
      in_coreid         = core;
   endtask

   task automatic idle_inputs();
      in_valid          = 1'b0;
      in_interrupt      = '0;
      in_exception      = '0;
      in_exception_pc   = '0;
      in_exception_inst = '0;
      in_coreid         = '0;
   endtask

   initial begin
      reset     = 1'b1;
      out_ready = 1'b0;
      idle_inputs();

      // ---- reset state ----
      step();
      check("rst_out_valid", a_out_valid, 0);
      check("rst_in_ready", a_in_ready, 1);
      check("rst_overflow", a_overflow, 0);
      check("rst_event_count", a_event_count, 0);
      check("rst_out_exception", a_out_exception, 0);
      check("rst_out_pc", a_out_exception_pc, 0);
      reset = 1'b0;

      // ---- single event, one-cycle latency ----
      drive_event(32'd0, 32'd2, 64'h0000_0000_8000_0010, 32'h0000_0073, 8'd3);
      out_ready = 1'b1;
      step();
      idle_inputs();
      #1;
      check("single_out_valid", a_out_valid, 1);
      check("single_out_exception", a_out_exception, 2);
      check("single_out_interrupt", a_out_interrupt, 0);
      check("single_out_pc", a_out_exception_pc, 64'h0000_0000_8000_0010);
      check("single_out_inst", a_out_exception_inst, 32'h0000_0073);
      check("single_out_coreid", a_out_coreid, 3);
      check("single_count_before", a_event_count, 0);
      step();
      check("single_drained_valid", a_out_valid, 0);
      check("single_drained_exc_zero", a_out_exception, 0);
      check("single_event_count", a_event_count, 1);

      // ---- non-real candidates are ignored ----
      drive_event(32'd0, 32'd0, 64'h1234, 32'h5678, 8'd1);
      step();
      check("nonreal_out_valid", a_out_valid, 0);
      check("nonreal_overflow", a_overflow, 0);
      check("nonreal_in_ready", a_in_ready, 1);
      in_valid     = 1'b0;
      in_exception = 32'd9;
      step();
      check("novalid_out_valid", a_out_valid, 0);
      idle_inputs();

      // ---- fill to full, fifth event dropped ----
      out_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         drive_event(32'd0, 32'(i), 64'h1000 + 64'(i), 32'h100 + 32'(i), 8'(i));
         step();
         if (i == 4) begin
            check("fill4_in_ready", a_in_ready, 0);
            check("fill4_overflow", a_overflow, 0);
         end
      end
      idle_inputs();
      #1;
      check("fill5_overflow", a_overflow, 1);
      check("fill5_in_ready", a_in_ready, 0);
      check("stall_head_exc", a_out_exception, 1);
      step();
      check("stall_hold_exc", a_out_exception, 1);
      check("stall_hold_pc", a_out_exception_pc, 64'h1001);

      out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         #1;
         check("order_exc", a_out_exception, 64'(k));
         check("order_coreid", a_out_coreid, 64'(k));
         step();
      end
      check("order_empty", a_out_valid, 0);
      check("order_overflow_sticky", a_overflow, 1);
      check("order_event_count", a_event_count, 5);
      check("sat_event_count_b", b_event_count, 3);

      // ---- both causes nonzero forwarded as-is ----
      out_ready = 1'b0;
      drive_event(32'd7, 32'd9, 64'hABCD, 32'h13, 8'd0);
      step();
      idle_inputs();
      #1;
      check("both_interrupt", a_out_interrupt, 7);
      check("both_exception", a_out_exception, 9);

      // ---- reset clears overflow and counters ----
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rst2_overflow", a_overflow, 0);
      check("rst2_event_count", a_event_count, 0);
      check("rst2_out_valid", a_out_valid, 0);

      // ---- full FIFO, simultaneous enqueue and dequeue ----
      for (int i = 11; i <= 14; i++) begin
         drive_event(32'd0, 32'(i), 64'(i), 32'(i), 8'd2);
         step();
      end
      check("full_in_ready", a_in_ready, 0);
      drive_event(32'd0, 32'd15, 64'd15, 32'd15, 8'd2);
      out_ready = 1'b1;
      #1;
      check("full_drain_in_ready", a_in_ready, 1);
      step();
      idle_inputs();
      out_ready = 1'b0;
      #1;
      check("simul_overflow", a_overflow, 0);
      check("simul_still_full", a_in_ready, 0);
      check("simul_head", a_out_exception, 12);
      out_ready = 1'b1;
      for (int k = 12; k <= 15; k++) begin
         #1;
         check("simul_order", a_out_exception, 64'(k));
         step();
      end
      check("simul_empty", a_out_valid, 0);
      check("simul_event_count", a_event_count, 5);
      check("sat2_event_count_b", b_event_count, 3);

      // ---- reset discards queued entries and wins over enqueue ----
      out_ready = 1'b0;
      for (int i = 21; i <= 23; i++) begin
         drive_event(32'd0, 32'(i), 64'(i), 32'(i), 8'd5);
         step();
      end
      check("pre_rst_valid", a_out_valid, 1);
      drive_event(32'd0, 32'd24, 64'd24, 32'd24, 8'd5);
      reset = 1'b1;
      step();
      reset = 1'b0;
      idle_inputs();
      #1;
      check("rst3_out_valid", a_out_valid, 0);
      check("rst3_event_count", a_event_count, 0);
      check("rst3_overflow", a_overflow, 0);
      check("rst3_in_ready", a_in_ready, 1);
      step();
      check("rst3_stays_empty", a_out_valid, 0);
      check("rst3_exc_zero", a_out_exception, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
